// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer: synchronizes the serial line, frames bytes LSB first,
// and hands them over through a single-entry valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_deser #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int BAUD_DIV = CLK_FREQ / BAUD,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       rx_overrun
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             rx_prev_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             ovr_reg, ovr_next;

  logic rx_s;
  logic rx_fall;
  logic baud_tick;
  logic sample_bit;
  logic deliver;
  logic handshake;

  assign rx_s      = sync2_reg;
  assign rx_fall   = rx_prev_reg & ~rx_s;
  assign baud_tick = (baud_cnt_reg == '0);
  assign handshake = valid_reg & rx_ready;

  // Line synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= rs232_rx;
      sync2_reg   <= sync1_reg;
      rx_prev_reg <= sync2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      ferr_reg     <= ferr_next;
      ovr_reg      <= ovr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_tick ? baud_cnt_reg : baud_cnt_reg - 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    sample_bit    = 1'b0;
    deliver       = 1'b0;
    ferr_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rx_fall) begin
          bit_cnt_next  = '0;
          baud_cnt_next = HALF_RELOAD;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (baud_tick) begin
          if (!rx_s) begin
            baud_cnt_next = BAUD_RELOAD;
            state_next    = ST_DATA;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          sample_bit    = 1'b1;
          baud_cnt_next = BAUD_RELOAD;
          if (bit_cnt_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Wait for the line to return high before hunting for a new start edge.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (sample_bit && (bit_cnt_reg == 3'(gi))) ? rx_s : shift_reg[gi];
    end
  endgenerate

  // A same-cycle handshake frees the holding register, so a new byte can land in it.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    ovr_next   = 1'b0;
    if (deliver) begin
      if (!valid_reg || rx_ready) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end else if (handshake) begin
      valid_next = 1'b0;
    end
  end

  assign rx_data    = data_reg;
  assign rx_valid   = valid_reg;
  assign rx_busy    = (state_reg != ST_IDLE);
  assign frame_err  = ferr_reg;
  assign rx_overrun = ovr_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at a scaled-down 16-cycle bit period:
// a table of single frames plus hand sequences for latency, glitch, break, overrun, reset and streaming.
`timescale 1ns/1ps
module tb_uart_rx_deser;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 16;
  localparam int HALF     = 8;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rs232_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_rx_deser #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .rx_overrun(rx_overrun)
  );

  int checks = 0;
  int errors = 0;

  // Cumulative event log, written only here and read by the stimulus.
  int         hs_cnt   = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         vcyc_cnt = 0;
  logic [7:0] hs_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vcyc_cnt++;
      if (rx_valid && rx_ready) begin
        hs_log.push_back(rx_data);
        hs_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (rx_overrun) ovr_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
    rs232_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      tick(DIV);
    end
    rs232_rx = stop;
    tick(DIV);
    if (!stop) begin
      tick(hold_low * DIV);
    end
    rs232_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    int         exp_hs;
    int         exp_ferr;
    int         exp_ovr;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s_hs, s_ferr, s_ovr, s_vcyc;
    int n;
    logic b3, b4;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 0, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 0, 1, 0, 1'b0, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1, 0, 0, 1'b0, 8'h81};
    vecs[5] = '{8'h11, 1'b1, 1'b0, 0, 0, 0, 1'b1, 8'h11};
    vecs[6] = '{8'h22, 1'b1, 1'b0, 0, 0, 1, 1'b1, 8'h11};

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset rx_busy", 32'(rx_busy), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset rx_overrun", 32'(rx_overrun), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // Exact latency: start edge to busy and to rx_valid
    s_hs = hs_cnt;
    n = 0; b3 = 1'bx; b4 = 1'bx;
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          n++;
          if (n == 3) b3 = rx_busy;
          if (n == 4) b4 = rx_busy;
          if (rx_valid) break;
        end
      end
    join
    tick(2 * DIV);
    check("busy before S+1", 32'(b3), 32'h0);
    check("busy at S+1", 32'(b4), 32'h1);
    check("valid latency", 32'(n), 32'(HALF + 9 * DIV + 4));
    check("latency byte count", 32'(hs_cnt - s_hs), 32'd1);
    if (hs_cnt > s_hs) check("latency byte", 32'(hs_log[s_hs]), 32'hC3);

    // Table of single frames
    foreach (vecs[r]) begin
      s_hs = hs_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt; s_vcyc = vcyc_cnt;
      rx_ready = vecs[r].ready;
      send_frame(vecs[r].data, vecs[r].stop, 0);
      tick(2 * DIV);
      check($sformatf("vec%0d bytes", r), 32'(hs_cnt - s_hs), 32'(vecs[r].exp_hs));
      if (vecs[r].exp_hs == 1 && hs_cnt > s_hs)
        check($sformatf("vec%0d byte", r), 32'(hs_log[s_hs]), 32'(vecs[r].exp_data));
      check($sformatf("vec%0d frame_err", r), 32'(ferr_cnt - s_ferr), 32'(vecs[r].exp_ferr));
      check($sformatf("vec%0d overrun", r), 32'(ovr_cnt - s_ovr), 32'(vecs[r].exp_ovr));
      check($sformatf("vec%0d rx_valid", r), 32'(rx_valid), 32'(vecs[r].exp_valid));
      check($sformatf("vec%0d rx_data", r), 32'(rx_data), 32'(vecs[r].exp_data));
      if (vecs[r].ready)
        check($sformatf("vec%0d valid cycles", r), 32'(vcyc_cnt - s_vcyc), 32'(vecs[r].exp_hs));
    end

    // Draining the held byte after the overrun
    s_hs = hs_cnt;
    rx_ready = 1'b1;
    tick(1);
    check("drain rx_valid", 32'(rx_valid), 32'h0);
    check("drain bytes", 32'(hs_cnt - s_hs), 32'd1);
    if (hs_cnt > s_hs) check("drain byte", 32'(hs_log[s_hs]), 32'h11);
    check("drain rx_data kept", 32'(rx_data), 32'h11);

    // Start glitch shorter than half a bit
    s_hs = hs_cnt; s_ferr = ferr_cnt;
    rs232_rx = 1'b0;
    tick(4);
    check("glitch busy", 32'(rx_busy), 32'h1);
    rs232_rx = 1'b1;
    tick(3 * DIV);
    check("glitch idle", 32'(rx_busy), 32'h0);
    check("glitch bytes", 32'(hs_cnt - s_hs), 32'd0);
    check("glitch frame_err", 32'(ferr_cnt - s_ferr), 32'd0);

    // Framing error with a held-low break, then a good frame
    s_hs = hs_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
    send_frame(8'h3C, 1'b0, 3);
    check("break busy", 32'(rx_busy), 32'h1);
    check("break frame_err", 32'(ferr_cnt - s_ferr), 32'd1);
    check("break no byte", 32'(hs_cnt - s_hs), 32'd0);
    tick(DIV);
    check("break released", 32'(rx_busy), 32'h0);
    send_frame(8'h5A, 1'b1, 0);
    tick(2 * DIV);
    check("after break bytes", 32'(hs_cnt - s_hs), 32'd1);
    if (hs_cnt > s_hs) check("after break byte", 32'(hs_log[s_hs]), 32'h5A);
    check("after break frame_err", 32'(ferr_cnt - s_ferr), 32'd1);
    check("after break overrun", 32'(ovr_cnt - s_ovr), 32'd0);

    // Reset during bit 4 of 0xF0, then 0x0F
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        tick(5 * DIV + DIV / 2);
        rst_n = 1'b0;
        tick(1);
        check("midreset rx_data", 32'(rx_data), 32'h00);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        check("midreset rx_busy", 32'(rx_busy), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        check("midreset rx_overrun", 32'(rx_overrun), 32'h0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(4);
    s_hs = hs_cnt; s_ferr = ferr_cnt;
    send_frame(8'h0F, 1'b1, 0);
    tick(2 * DIV);
    check("post-reset bytes", 32'(hs_cnt - s_hs), 32'd1);
    if (hs_cnt > s_hs) check("post-reset byte", 32'(hs_log[s_hs]), 32'h0F);
    check("post-reset frame_err", 32'(ferr_cnt - s_ferr), 32'd0);

    // Back-to-back stream 0x00..0xFF with one stop bit
    s_hs = hs_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1, 0);
    end
    tick(2 * DIV);
    check("stream bytes", 32'(hs_cnt - s_hs), 32'd256);
    check("stream frame_err", 32'(ferr_cnt - s_ferr), 32'd0);
    check("stream overrun", 32'(ovr_cnt - s_ovr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (s_hs + i < hs_cnt) check($sformatf("stream byte %0d", i), 32'(hs_log[s_hs + i]), 32'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
